// File: rtl/jpeg_mcu_scheduler.sv
// Walks the MCU grid of a baseline JPEG scan, labelling each accepted block with
// component, quant table and MCU position, and pausing for RSTn markers at restart boundaries.
module jpeg_mcu_scheduler #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_scan,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic [2:0]       comp0_h_samp,
  input  logic [2:0]       comp0_v_samp,
  input  logic [5:0]       quant_id_flat,
  input  logic [15:0]      restart_interval,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             ds_ready,
  output logic [1:0]       comp_idx,
  output logic [1:0]       q_sel,
  output logic [2:0]       blk_in_mcu,
  output logic [DIM_W-1:0] mcu_x,
  output logic [DIM_W-1:0] mcu_y,
  output logic             dc_pred_clr,
  output logic             rst_marker_expect,
  input  logic             rst_marker_seen,
  output logic             scan_done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, RSTW, DONE} state_t;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t           state, state_n;
  logic             mode420, mode420_n;
  logic [DIM_W-1:0] mcus_x, mcus_y, mcus_x_n, mcus_y_n;
  logic [5:0]       quant_q;
  logic [15:0]      ri_q, rst_cnt, rst_cnt_inc;
  logic [DIM_W:0]   w_sum, h_sum, w_sh, h_sh;
  logic [2:0]       blk_last;
  logic             accept, mcu_done, x_wrap, last_mcu, ri_hit, marker_ok;

  // MCU grid size from the live inputs, one extra bit so rounding up cannot overflow
  always_comb begin
    mode420_n = (comp0_h_samp == 3'd2) && (comp0_v_samp == 3'd2);
    w_sum     = {1'b0, img_width}  + (mode420_n ? (DIM_W+1)'(15) : (DIM_W+1)'(7));
    h_sum     = {1'b0, img_height} + (mode420_n ? (DIM_W+1)'(15) : (DIM_W+1)'(7));
    w_sh      = mode420_n ? (w_sum >> 4) : (w_sum >> 3);
    h_sh      = mode420_n ? (h_sum >> 4) : (h_sum >> 3);
    mcus_x_n  = w_sh[DIM_W-1:0];
    mcus_y_n  = h_sh[DIM_W-1:0];
  end

  assign blk_last    = mode420 ? 3'd5 : 3'd2;
  assign accept      = blk_valid && blk_ready;
  assign mcu_done    = accept && (blk_in_mcu == blk_last);
  assign x_wrap      = (mcu_x == mcus_x - ONE);
  assign last_mcu    = x_wrap && (mcu_y == mcus_y - ONE);
  assign rst_cnt_inc = rst_cnt + 16'd1;
  assign ri_hit      = (ri_q != 16'd0) && (rst_cnt_inc == ri_q);
  assign marker_ok   = (state == RSTW) && rst_marker_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_scan)
      state_n = ((mcus_x_n == '0) || (mcus_y_n == '0)) ? DONE : RUN;
    else begin
      case (state)
        RUN:     if (mcu_done) state_n = last_mcu ? DONE : (ri_hit ? RSTW : RUN);
        RSTW:    if (rst_marker_seen) state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    blk_ready         = (state == RUN) && ds_ready && !start_scan;
    busy              = (state == RUN) || (state == RSTW);
    scan_done         = (state == DONE);
    rst_marker_expect = (state == RSTW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode420     <= 1'b0;
      mcus_x      <= '0;
      mcus_y      <= '0;
      quant_q     <= '0;
      ri_q        <= '0;
      rst_cnt     <= '0;
      blk_in_mcu  <= '0;
      mcu_x       <= '0;
      mcu_y       <= '0;
      dc_pred_clr <= 1'b0;
    end else begin
      dc_pred_clr <= start_scan || marker_ok;
      if (start_scan) begin
        mode420    <= mode420_n;
        mcus_x     <= mcus_x_n;
        mcus_y     <= mcus_y_n;
        quant_q    <= quant_id_flat;
        ri_q       <= restart_interval;
        rst_cnt    <= '0;
        blk_in_mcu <= '0;
        mcu_x      <= '0;
        mcu_y      <= '0;
      end else begin
        if (accept) blk_in_mcu <= (blk_in_mcu == blk_last) ? 3'd0 : blk_in_mcu + 3'd1;
        if (mcu_done) begin
          rst_cnt <= rst_cnt_inc;
          if (x_wrap) begin
            mcu_x <= '0;
            mcu_y <= mcu_y + ONE;
          end else begin
            mcu_x <= mcu_x + ONE;
          end
        end
        if (marker_ok) rst_cnt <= '0;
      end
    end
  end

  // 4:2:0 MCU is Y0..Y3, Cb, Cr; otherwise one block per component
  always_comb begin
    if (mode420) comp_idx = (blk_in_mcu < 3'd4) ? 2'd0 : ((blk_in_mcu == 3'd4) ? 2'd1 : 2'd2);
    else         comp_idx = blk_in_mcu[1:0];
    case (comp_idx)
      2'd0:    q_sel = quant_q[1:0];
      2'd1:    q_sel = quant_q[3:2];
      default: q_sel = quant_q[5:4];
    endcase
  end
endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Scoreboard bench: a block-list model of each scan feeds a queue, a negedge monitor checks accepts.
module tb_jpeg_mcu_scheduler;
  logic        clk = 0, rst = 1;
  logic        start_scan = 0, blk_valid = 0, ds_ready = 0, rst_marker_seen = 0;
  logic [15:0] img_width = 0, img_height = 0, restart_interval = 0;
  logic [2:0]  comp0_h_samp = 0, comp0_v_samp = 0;
  logic [5:0]  quant_id_flat = 0;
  logic        blk_ready, dc_pred_clr, rst_marker_expect, scan_done, busy;
  logic [1:0]  comp_idx, q_sel;
  logic [2:0]  blk_in_mcu;
  logic [15:0] mcu_x, mcu_y;

  jpeg_mcu_scheduler #(.DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start_scan(start_scan), .img_width(img_width),
    .img_height(img_height), .comp0_h_samp(comp0_h_samp), .comp0_v_samp(comp0_v_samp),
    .quant_id_flat(quant_id_flat), .restart_interval(restart_interval),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .ds_ready(ds_ready),
    .comp_idx(comp_idx), .q_sel(q_sel), .blk_in_mcu(blk_in_mcu), .mcu_x(mcu_x),
    .mcu_y(mcu_y), .dc_pred_clr(dc_pred_clr), .rst_marker_expect(rst_marker_expect),
    .rst_marker_seen(rst_marker_seen), .scan_done(scan_done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int comp, q, blk, mx, my;
    bit rstw, last;
  } exp_t;
  exp_t exp_q[$];
  int   nchk = 0, nfail = 0;

  task automatic chk(input string name, input int act, input int want);
    nchk++;
    if (act != want) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Expected block stream of a whole scan, straight from the MCU ordering rules.
  task automatic model_scan(input int w, h, hs, vs, qid, ri);
    bit m = (hs == 2) && (vs == 2);
    int nx = m ? (w + 15) / 16 : (w + 7) / 8;
    int ny = m ? (h + 15) / 16 : (h + 7) / 8;
    int nb = m ? 6 : 3;
    int total = nx * ny;
    for (int i = 0; i < total; i++)
      for (int b = 0; b < nb; b++) begin
        exp_t e;
        e.comp = m ? ((b < 4) ? 0 : b - 3) : b;
        e.q    = (qid >> (2 * e.comp)) & 3;
        e.blk  = b;
        e.mx   = i % nx;
        e.my   = i / nx;
        e.last = (b == nb - 1) && (i == total - 1);
        e.rstw = (b == nb - 1) && (ri != 0) && ((i + 1) % ri == 0) && !e.last;
        exp_q.push_back(e);
      end
  endtask

  // Monitor: a block offered with valid&&ready at negedge is accepted at the next posedge;
  // the negedge after that must show the resulting restart/done status.
  bit post_chk = 0;
  exp_t last_e;
  always @(negedge clk) begin
    if (rst) post_chk = 0;
    else begin
      if (post_chk) begin
        chk("rst_marker_expect_after_accept", rst_marker_expect, last_e.rstw);
        chk("scan_done_after_accept", scan_done, last_e.last);
        post_chk = 0;
      end
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          last_e = exp_q.pop_front();
          chk("comp_idx", comp_idx, last_e.comp);
          chk("q_sel", q_sel, last_e.q);
          chk("blk_in_mcu", blk_in_mcu, last_e.blk);
          chk("mcu_x", mcu_x, last_e.mx);
          chk("mcu_y", mcu_y, last_e.my);
          post_chk = 1;
        end
      end
    end
  end

  task automatic start(input int w, h, hs, vs, qid, ri);
    model_scan(w, h, hs, vs, qid, ri);
    img_width = 16'(w); img_height = 16'(h);
    comp0_h_samp = 3'(hs); comp0_v_samp = 3'(vs);
    quant_id_flat = 6'(qid); restart_interval = 16'(ri);
    start_scan = 1;
    @(posedge clk); #1;
    start_scan = 0;
    chk("dc_pred_clr_after_start", dc_pred_clr, 1);
  endtask

  task automatic drive_scan(input int bp_pct, input int budget);
    int cyc = 0;
    while (!scan_done && cyc < budget) begin
      ds_ready  = ($urandom_range(0, 99) >= bp_pct);
      blk_valid = ($urandom_range(0, 9) != 0);
      rst_marker_seen = rst_marker_expect ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    blk_valid = 0; ds_ready = 0; rst_marker_seen = 0;
    chk("scan_done_end", scan_done, 1);
    chk("blocks_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic accepts(input int n);
    blk_valid = 1; ds_ready = 1;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    blk_valid = 0; ds_ready = 0;
  endtask

  initial begin
    #12;
    chk("reset_blk_ready", blk_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_scan_done", scan_done, 0);
    chk("reset_dc_pred_clr", dc_pred_clr, 0);
    chk("reset_mcu_x", mcu_x, 0);
    @(posedge clk); #1; rst = 0;

    // 16x16 4:2:0, one MCU
    start(16, 16, 2, 2, 6'b01_01_00, 0);
    drive_scan(0, 200);

    // 24x8 4:4:4, three MCUs in a row
    start(24, 8, 1, 1, 6'b10_01_00, 0);
    drive_scan(0, 200);

    // restart every MCU, 2 MCUs: one RSTW only
    start(32, 16, 2, 2, 6'b11_10_01, 1);
    blk_valid = 1; ds_ready = 1;
    for (int i = 0; i < 50 && !rst_marker_expect; i++) begin @(posedge clk); #1; end
    chk("rstw_reached", rst_marker_expect, 1);
    chk("rstw_blk_ready", blk_ready, 0);
    chk("rstw_busy", busy, 1);
    chk("rstw_blocks_left", exp_q.size(), 6);
    rst_marker_seen = 1;
    @(posedge clk); #1;
    rst_marker_seen = 0;
    chk("marker_dc_pred_clr", dc_pred_clr, 1);
    chk("marker_expect_clear", rst_marker_expect, 0);
    chk("marker_blk_ready", blk_ready, 1);
    drive_scan(0, 200);

    // backpressure holds position
    start(16, 16, 1, 1, 6'b00_10_01, 0);
    accepts(2);
    blk_valid = 1; ds_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_blk_ready", blk_ready, 0);
      chk("bp_blk_in_mcu", blk_in_mcu, 2);
      chk("bp_mcu_x", mcu_x, 0);
    end
    ds_ready = 1;
    @(posedge clk); #1;
    blk_valid = 0; ds_ready = 0;
    chk("bp_release_blk", blk_in_mcu, 0);
    chk("bp_release_mcu_x", mcu_x, 1);
    drive_scan(30, 500);

    // reset mid-scan discards progress
    start(16, 16, 2, 2, 6'b10_01_11, 0);
    accepts(3);
    rst = 1; ds_ready = 1;
    #2;
    exp_q.delete();
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_in_mcu", blk_in_mcu, 0);
    chk("rst_comp_idx", comp_idx, 0);
    chk("rst_marker_expect", rst_marker_expect, 0);
    chk("rst_scan_done", scan_done, 0);
    @(posedge clk); #1;
    rst = 0; ds_ready = 0;
    start(16, 16, 2, 2, 6'b10_01_11, 0);
    drive_scan(0, 200);

    // zero width: straight to DONE, never ready
    start(0, 16, 1, 1, 0, 0);
    chk("zero_w_scan_done", scan_done, 1);
    blk_valid = 1; ds_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("zero_w_blk_ready", blk_ready, 0);
    end
    blk_valid = 0; ds_ready = 0;

    // random scans
    for (int s = 0; s < 20; s++) begin
      int hs = $urandom_range(1, 2);
      int vs = $urandom_range(0, 3) == 0 ? 1 : hs;
      start($urandom_range(0, 40), $urandom_range(0, 40), hs, vs,
            $urandom_range(0, 63), $urandom_range(0, 3));
      drive_scan(30, 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/jpeg_mcu_scheduler.md
JPEG_MCU_SCHEDULER -- requirements
Module: jpeg_mcu_scheduler

Interface
REQ-001 SHALL have parameter DIM_W, default 16: width of image-dimension and MCU-position fields.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_scan  in  1  one-cycle pulse from the header parser at SOS.
REQ-005 SHALL have port img_width, img_height  in  DIM_W each  image size in pixels.
REQ-006 SHALL have port comp0_h_samp, comp0_v_samp  in  3 each  sampling factors of component 0.
REQ-007 SHALL have port quant_id_flat  in  6  quant table id per component, 2 bits each, comp0 in bits [1:0].
REQ-008 SHALL have port restart_interval  in  16  MCUs per restart interval; 0 means disabled.
REQ-009 SHALL have port blk_valid  in  1  coefficient accumulator holds a complete block.
REQ-010 SHALL have port blk_ready  out  1  block accepted this cycle when high together with blk_valid.
REQ-011 SHALL have port ds_ready  in  1  MCU manager can take a block.
REQ-012 SHALL have port comp_idx  out  2  component of the block currently offered.
REQ-013 SHALL have port q_sel  out  2  quant table id for comp_idx.
REQ-014 SHALL have port blk_in_mcu  out  3  block index within the current MCU.
REQ-015 SHALL have port mcu_x, mcu_y  out  DIM_W each  current MCU position.
REQ-016 SHALL have port dc_pred_clr  out  1  one-cycle pulse that clears all DC predictors.
REQ-017 SHALL have port rst_marker_expect  out  1  level; waiting for an RSTn marker.
REQ-018 SHALL have port rst_marker_seen  in  1  pulse; bitstream reader consumed an RSTn marker.
REQ-019 SHALL have port scan_done  out  1  level; all MCUs of the scan accepted.
REQ-020 SHALL have port busy  out  1  high in RUN or RSTW.

Function
REQ-021 SHALL implement states IDLE, RUN, RSTW, DONE.
REQ-022 On start_scan in any state, SHALL do all of the following:
- latch config;
- set mode420 = (comp0_h_samp==2 && comp0_v_samp==2);
- set mcus_x = mode420 ? (img_width+15)>>4 : (img_width+7)>>3, and mcus_y likewise from img_height;
- clear all counters;
- pulse dc_pred_clr on the next cycle;
- enter RUN, or enter DONE if mcus_x==0 or mcus_y==0.
REQ-023 blk_ready SHALL equal (state==RUN) && ds_ready && !start_scan, combinationally.
REQ-024 On each accept, blk_in_mcu SHALL advance, wrapping to 0 after 5 (mode420) or 2 (otherwise); each wrap completes one MCU.
REQ-025 comp_idx SHALL be as follows:
- mode420: 0 for blk_in_mcu 0-3, 1 for 4, 2 for 5;
- otherwise: comp_idx = blk_in_mcu.
REQ-026 q_sel SHALL be the quant_id_flat field latched at start_scan for comp_idx, combinationally.
REQ-027 On MCU completion, mcu_x SHALL increment; at mcus_x-1 it SHALL wrap to 0 and mcu_y SHALL increment.
REQ-028 An internal 16-bit counter SHALL count MCUs completed since the last restart.
REQ-029 When that counter reaches a nonzero restart_interval and the MCU is not the last of the scan, the block SHALL enter RSTW, set rst_marker_expect=1 and hold blk_ready=0.
REQ-030 In RSTW, rst_marker_seen SHALL cause all of the following:
- pulse dc_pred_clr on the next cycle;
- clear the restart counter;
- clear rst_marker_expect;
- return to RUN.
REQ-031 rst_marker_seen outside RSTW SHALL be ignored.
REQ-032 Completion of MCU (mcus_x-1, mcus_y-1) SHALL enter DONE and set scan_done=1; this takes priority over RSTW.
REQ-033 In DONE, blk_valid SHALL be ignored and scan_done SHALL hold until the next start_scan or rst.
REQ-034 blk_valid held high while ds_ready=0 SHALL NOT advance any counter.
REQ-035 Counters SHALL wrap modulo 2^DIM_W without error flagging.

Reset
REQ-036 On rst assertion, the block SHALL asynchronously enter IDLE.
REQ-037 All outputs and counters SHALL reset to 0, including blk_ready, dc_pred_clr, rst_marker_expect, scan_done and busy.
REQ-038 rst mid-scan SHALL discard all progress; operation resumes only on a new start_scan.

Verification
REQ-039 The bench SHALL cover: 16x16, h=v=2, ri=0, 6 accepts -> comp_idx 0,0,0,0,1,2; q_sel follows quant_id_flat=6'b01_01_00 (0,0,0,0,1,1); scan_done=1 after the 6th accept.
REQ-040 The bench SHALL cover: 24x8, h=v=1, 9 accepts -> mcu_x sequence 0,1,2; comp_idx cycles 0,1,2; scan_done after the 9th accept.
REQ-041 The bench SHALL cover the restart sequence for 32x16, 4:2:0, ri=1:
- after 6 accepts, rst_marker_expect=1 and blk_ready=0 with ds_ready=1;
- rst_marker_seen -> dc_pred_clr pulse, then RUN;
- 6 more accepts -> DONE with no second RSTW.
REQ-042 The bench SHALL cover backpressure: ds_ready=0 for 3 cycles with blk_valid=1 -> blk_ready=0 and counters unchanged; ds_ready=1 -> one accept.
REQ-043 The bench SHALL cover rst pulse after 3 accepts -> all outputs 0 and state IDLE; a new start_scan restarts from block 0 with a dc_pred_clr pulse.
REQ-044 The bench SHALL cover img_width=0 with start_scan -> scan_done=1 next cycle and blk_ready never high.
